// File: rtl/tc_stack_alu.sv
// tc_stack_alu
// Stack-machine sequencer sitting directly in front of a WIDTH-bit hardware
// stack. One command is accepted at a time. Each command becomes a short
// sequence of single-cycle push/pop strobes, and exactly one response is
// returned per command. The block keeps its own entry count, so it can reject
// underflow and overflow at accept time without touching the stack.
//
// Ports:
//   clk, rst                      clock (posedge), async active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_op[2:0], cmd_imm          opcode (PUSH,POP,DUP,ADD,SUB,AND,OR,XOR), PUSH operand
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err, rsp_carry  result, error flag, carry/borrow
//   depth                         current entry count
//   stk_push, stk_pop, stk_wdata  strobes and push data to the stack
//   stk_rdata                     stack output, valid the cycle after a pop
module tc_stack_alu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             rsp_carry,
  output logic [DW-1:0]    depth,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata
);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_DUP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP1  = 3'd1,
    LAT1  = 3'd2,
    POP2  = 3'd3,
    LAT2  = 3'd4,
    PUSH1 = 3'd5,
    PUSH2 = 3'd6,
    RESP  = 3'd7
  } state_t;

  state_t           state_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] imm_r;
  logic [WIDTH-1:0] a_r;     // second entry (left operand)
  logic [WIDTH-1:0] b_r;     // top entry (right operand)
  logic             legal_s;

  // Binary-op result, modulo 2^WIDTH; non-ALU opcodes yield 0.
  function automatic logic [WIDTH-1:0] alu_result_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // ADD carry-out / SUB borrow; 0 for every other opcode.
  // A truncated sum smaller than an addend means the add wrapped.
  function automatic logic alu_carry_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] s;
    logic             c;
    s = a + b;
    case (op)
      OP_ADD:  c = (s < a);
      OP_SUB:  c = (a < b);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Legality of the offered command against the current depth.
  always_comb begin
    legal_s = 1'b0;
    case (cmd_op)
      OP_PUSH: legal_s = (depth < DEPTH_MAX);
      OP_POP:  legal_s = (depth >= ONE);
      OP_DUP:  legal_s = (depth >= ONE) && (depth < DEPTH_MAX);
      default: legal_s = (depth >= TWO);
    endcase
  end

  // Sequencer FSM with registered strobes, response and depth counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 3'd0;
      imm_r     <= {WIDTH{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      depth     <= {DW{1'b0}};
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= {WIDTH{1'b0}};
      rsp_err   <= 1'b0;
      rsp_carry <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= {WIDTH{1'b0}};
    end else begin
      // Strobes last one cycle unless the next state re-asserts them.
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= {WIDTH{1'b0}};

      // Depth follows the strobe that is ending on this edge.
      if (stk_push) begin
        depth <= depth + ONE;
      end else if (stk_pop) begin
        depth <= depth - ONE;
      end else begin
        depth <= depth;
      end

      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_r      <= cmd_op;
            imm_r     <= cmd_imm;
            if (!legal_s) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= {WIDTH{1'b0}};
              rsp_carry <= 1'b0;
            end else if (cmd_op == OP_PUSH) begin
              state_r   <= PUSH1;
              stk_push  <= 1'b1;
              stk_wdata <= cmd_imm;
            end else begin
              state_r <= POP1;
              stk_pop <= 1'b1;
            end
          end
        end
        POP1: state_r <= LAT1;
        LAT1: begin
          b_r <= stk_rdata;
          case (op_r)
            OP_POP: begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= stk_rdata;
            end
            OP_DUP: begin
              state_r   <= PUSH1;
              stk_push  <= 1'b1;
              stk_wdata <= stk_rdata;
            end
            default: begin
              state_r <= POP2;
              stk_pop <= 1'b1;
            end
          endcase
        end
        POP2: state_r <= LAT2;
        LAT2: begin
          // stk_rdata here is the second entry; the result is pushed next cycle.
          a_r       <= stk_rdata;
          state_r   <= PUSH1;
          stk_push  <= 1'b1;
          stk_wdata <= alu_result_f(op_r, stk_rdata, b_r);
        end
        PUSH1: begin
          if (op_r == OP_DUP) begin
            state_r   <= PUSH2;
            stk_push  <= 1'b1;
            stk_wdata <= b_r;
          end else begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= (op_r == OP_PUSH) ? imm_r : stk_wdata;
            rsp_carry <= alu_carry_f(op_r, a_r, b_r);
          end
        end
        PUSH2: begin
          state_r   <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= b_r;
        end
        RESP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= {WIDTH{1'b0}};
            rsp_err   <= 1'b0;
            rsp_carry <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_data  <= {WIDTH{1'b0}};
          rsp_err   <= 1'b0;
          rsp_carry <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_stack_alu.sv
// Testbench for tc_stack_alu: behavioural stack model, table-driven command
// vectors with hand-computed results, plus fill/overflow, response
// back-pressure and mid-command reset sequences.
module tb_tc_stack_alu;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_DUP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_carry;
  logic [8:0] depth;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;

  int checks = 0;
  int errors = 0;
  int push_total = 0;
  int pop_total = 0;
  int both_cnt = 0;

  // Attached stack model
  logic [7:0] mem [0:255];
  int         sp;

  tc_stack_alu dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_carry(rsp_carry), .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= 0;
      stk_rdata <= 8'h00;
    end else if (stk_push && sp < 256) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_rdata <= mem[sp-1];
      sp        <= sp - 1;
    end
  end

  always @(posedge clk) begin
    if (stk_push) push_total <= push_total + 1;
    if (stk_pop) pop_total <= pop_total + 1;
    if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command, wait for its response (bounded), optionally hold
  // rsp_ready low for 'hold' cycles checking stability, then consume it.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm, input int hold,
                        input logic [7:0] hold_exp,
                        output logic [7:0] d, output logic e, output logic c,
                        output int lat, output int np, output int npo);
    int w;
    int p0;
    int q0;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    p0 = push_total;
    q0 = pop_total;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_imm   = 8'h00;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d   = rsp_data;
    e   = rsp_err;
    c   = rsp_carry;
    np  = push_total - p0;
    npo = pop_total - q0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp", {54'd0, rsp_valid, rsp_data, cmd_ready}, {54'd0, 1'b1, hold_exp, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", {53'd0, rsp_valid, rsp_err, rsp_carry, rsp_data},
          {53'd0, 1'b0, 1'b0, 1'b0, 8'h00});
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] data;
    logic       err;
    logic       carry;
    int         dep;
    int         lat;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic [7:0] d;
    logic       e;
    logic       c;
    int         lat;
    int         np;
    int         npo;
    int         ep;
    int         epo;
    int         fill_err;

    //              op       imm    data   err   carry depth lat
    vecs[0]  = '{OP_PUSH, 8'h05, 8'h05, 1'b0, 1'b0, 1, 2};
    vecs[1]  = '{OP_PUSH, 8'h03, 8'h03, 1'b0, 1'b0, 2, 2};
    vecs[2]  = '{OP_ADD,  8'h00, 8'h08, 1'b0, 1'b0, 1, 6};
    vecs[3]  = '{OP_PUSH, 8'hF0, 8'hF0, 1'b0, 1'b0, 2, 2};
    vecs[4]  = '{OP_PUSH, 8'h20, 8'h20, 1'b0, 1'b0, 3, 2};
    vecs[5]  = '{OP_ADD,  8'h00, 8'h10, 1'b0, 1'b1, 2, 6};
    vecs[6]  = '{OP_PUSH, 8'h11, 8'h11, 1'b0, 1'b0, 3, 2};
    vecs[7]  = '{OP_SUB,  8'h00, 8'hFF, 1'b0, 1'b1, 2, 6};
    vecs[8]  = '{OP_AND,  8'h00, 8'h08, 1'b0, 1'b0, 1, 6};
    vecs[9]  = '{OP_POP,  8'h00, 8'h08, 1'b0, 1'b0, 0, 3};
    vecs[10] = '{OP_POP,  8'h00, 8'h00, 1'b1, 1'b0, 0, 1};
    vecs[11] = '{OP_PUSH, 8'hAA, 8'hAA, 1'b0, 1'b0, 1, 2};
    vecs[12] = '{OP_DUP,  8'h00, 8'hAA, 1'b0, 1'b0, 2, 5};
    vecs[13] = '{OP_POP,  8'h00, 8'hAA, 1'b0, 1'b0, 1, 3};
    vecs[14] = '{OP_POP,  8'h00, 8'hAA, 1'b0, 1'b0, 0, 3};
    vecs[15] = '{OP_PUSH, 8'h0C, 8'h0C, 1'b0, 1'b0, 1, 2};
    vecs[16] = '{OP_ADD,  8'h00, 8'h00, 1'b1, 1'b0, 1, 1};
    vecs[17] = '{OP_PUSH, 8'h0A, 8'h0A, 1'b0, 1'b0, 2, 2};
    vecs[18] = '{OP_OR,   8'h00, 8'h0E, 1'b0, 1'b0, 1, 6};
    vecs[19] = '{OP_POP,  8'h00, 8'h0E, 1'b0, 1'b0, 0, 3};
    vecs[20] = '{OP_DUP,  8'h00, 8'h00, 1'b1, 1'b0, 0, 1};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_imm   = 8'h00;
    rsp_ready = 1'b0;
    #1;
    check("reset_outputs",
          {33'd0, cmd_ready, rsp_valid, rsp_err, rsp_carry, rsp_data, stk_push, stk_pop, stk_wdata, depth},
          {33'd0, 1'b1, 30'd0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven command vectors
    for (int i = 0; i < 21; i++) begin
      do_cmd(vecs[i].op, vecs[i].imm, 0, 8'h00, d, e, c, lat, np, npo);
      if (vecs[i].err) begin
        ep = 0; epo = 0;
      end else begin
        case (vecs[i].op)
          OP_PUSH: begin ep = 1; epo = 0; end
          OP_POP:  begin ep = 0; epo = 1; end
          OP_DUP:  begin ep = 2; epo = 1; end
          default: begin ep = 1; epo = 2; end
        endcase
      end
      check($sformatf("v%0d_data", i), {56'd0, d}, {56'd0, vecs[i].data});
      check($sformatf("v%0d_err", i), {63'd0, e}, {63'd0, vecs[i].err});
      check($sformatf("v%0d_carry", i), {63'd0, c}, {63'd0, vecs[i].carry});
      check($sformatf("v%0d_depth", i), {55'd0, depth}, 64'(vecs[i].dep));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_pushes", i), 64'(np), 64'(ep));
      check($sformatf("v%0d_pops", i), 64'(npo), 64'(epo));
    end

    // Fill to capacity, then overflow and an XOR on a full stack
    fill_err = 0;
    for (int i = 0; i < 256; i++) begin
      do_cmd(OP_PUSH, 8'(i), 0, 8'h00, d, e, c, lat, np, npo);
      if (e) fill_err++;
    end
    check("fill_errors", 64'(fill_err), 64'd0);
    check("fill_depth", {55'd0, depth}, 64'd256);
    do_cmd(OP_PUSH, 8'h77, 0, 8'h00, d, e, c, lat, np, npo);
    check("ovf_err", {63'd0, e}, 64'd1);
    check("ovf_latency", 64'(lat), 64'd1);
    check("ovf_strobes", 64'(np + npo), 64'd0);
    check("ovf_depth", {55'd0, depth}, 64'd256);
    do_cmd(OP_DUP, 8'h00, 0, 8'h00, d, e, c, lat, np, npo);
    check("dup_full_err", {63'd0, e}, 64'd1);
    do_cmd(OP_XOR, 8'h00, 0, 8'h00, d, e, c, lat, np, npo);
    check("xor_data", {56'd0, d}, 64'h01);
    check("xor_err", {63'd0, e}, 64'd0);
    check("xor_depth", {55'd0, depth}, 64'd255);
    check("xor_stack_top", {56'd0, mem[254]}, 64'h01);

    // Response back-pressure: hold rsp_ready low for 5 cycles on an ADD
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_cmd(OP_PUSH, 8'h03, 0, 8'h00, d, e, c, lat, np, npo);
    do_cmd(OP_PUSH, 8'h04, 0, 8'h00, d, e, c, lat, np, npo);
    do_cmd(OP_ADD, 8'h00, 5, 8'h07, d, e, c, lat, np, npo);
    check("hold_add_data", {56'd0, d}, 64'h07);
    check("hold_add_depth", {55'd0, depth}, 64'd1);

    // Reset during LAT1 of an ADD aborts with no response
    do_cmd(OP_PUSH, 8'h09, 0, 8'h00, d, e, c, lat, np, npo);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    @(negedge clk);                 // cycle 1: POP1
    cmd_valid = 1'b0;
    @(negedge clk);                 // cycle 2: LAT1
    rst = 1'b1;
    #1;
    check("midcmd_reset_outputs",
          {33'd0, cmd_ready, rsp_valid, rsp_err, rsp_carry, rsp_data, stk_push, stk_pop, stk_wdata, depth},
          {33'd0, 1'b1, 30'd0});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midcmd_no_rsp", {62'd0, rsp_valid, stk_push}, 64'd0);
    end
    check("midcmd_depth", {55'd0, depth}, 64'd0);

    check("push_pop_exclusive", 64'(both_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
